// File: rtl/fft_dif_sequencer_pkg.sv
// Shared defaults and types for the radix-2 DIF FFT sequencer.
// Parameters here are defaults only; modules take their own overrides.
package fft_pkg;

  localparam int N_POINTS       = 256;
  localparam int LOG2N          = $clog2(N_POINTS);
  localparam int BFLY_LATENCY   = 3;
  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [LOG2N-2:0] tw_addr_t;

endpackage

// File: rtl/fft_dif_sequencer_if.sv
// Sample RAM, twiddle ROM and butterfly_unit control bundle driven by the sequencer.
// Master is the sequencer; slave is the RAM/butterfly side. No backpressure.
interface fft_dif_sequencer_if #(
  parameter int LOG2N = 8
);

  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             bfly_en;
  logic             bfly_valid_in;
  logic             bfly_valid_out;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output bfly_en, bfly_valid_in, wr_en, wr_addr_a, wr_addr_b,
    input  bfly_valid_out
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  bfly_en, bfly_valid_in, wr_en, wr_addr_a, wr_addr_b,
    output bfly_valid_out
  );

endinterface

// File: rtl/fft_dif_sequencer_addr_gen.sv
// Combinational (stage, k) -> butterfly pair and twiddle index; zero latency.
// Shared with the bit-reverse output reader, so it stays free of sequencer state.
module fft_addr_gen #(
  parameter int LOG2N = 8
) (
  input  logic [LOG2N-1:0] stage,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);

  localparam logic [LOG2N-1:0] HALF = LOG2N'(1) << (LOG2N - 1);

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] j;

  // span = N >> (stage+1); the group bits of k move up one place to skip the B half
  always_comb begin
    span    = HALF >> stage;
    mask    = span - LOG2N'(1);
    k_ext   = {1'b0, k};
    j       = k_ext & mask;
    addr_a  = ((k_ext & ~mask) << 1) | j;
    addr_b  = addr_a | span;
    tw_addr = (LOG2N-1)'(j << stage);
  end

endmodule

// File: rtl/fft_dif_sequencer.sv
// In-place radix-2 DIF FFT controller: one butterfly per cycle, drains D cycles per stage.
// Reads at cycle 1 after start, writes D later; no backpressure, results left bit-reversed.
module fft_dif_sequencer
  import fft_pkg::*;
#(
  parameter int N_POINTS       = fft_pkg::N_POINTS,
  parameter int BFLY_LATENCY   = fft_pkg::BFLY_LATENCY,
  parameter int MEM_RD_LATENCY = fft_pkg::MEM_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_POINTS)-1:0] stage,
  output logic                        sync_err,
  fft_dif_sequencer_if.master         mem
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam int KW    = LOG2N - 1;
  localparam int D     = MEM_RD_LATENCY + BFLY_LATENCY;
  localparam int DCW   = $clog2(D + 1);

  localparam logic [KW-1:0]    K_LAST = {KW{1'b1}};
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
  localparam logic [DCW-1:0]   D_LAST = DCW'(D - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic [DCW-1:0]   drain_cnt;
  logic             rd_en_q;
  logic             bfly_en_q;
  logic [D-1:0]     rd_pipe;
  logic [LOG2N-1:0] a_pipe [D];
  logic [LOG2N-1:0] b_pipe [D];
  logic [LOG2N-1:0] ag_a;
  logic [LOG2N-1:0] ag_b;
  logic [LOG2N-2:0] ag_tw;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage   (stage),
    .k       (k),
    .addr_a  (ag_a),
    .addr_b  (ag_b),
    .tw_addr (ag_tw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en_q   <= 1'b0;
      bfly_en_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            stage     <= '0;
            k         <= '0;
            busy      <= 1'b1;
            rd_en_q   <= 1'b1;
            bfly_en_q <= 1'b1;
          end
        end
        ISSUE: begin
          k <= k + KW'(1);
          if (k == K_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            rd_en_q   <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DCW'(1);
          // the last write of this stage lands in the final drain cycle
          if (drain_cnt == D_LAST) begin
            if (stage == S_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              stage   <= stage + LOG2N'(1);
              k       <= '0;
              rd_en_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          stage     <= '0;
          busy      <= 1'b0;
          bfly_en_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe  <= '0;
      sync_err <= 1'b0;
      for (int i = 0; i < D; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      rd_pipe   <= {rd_pipe[D-2:0], rd_en_q};
      a_pipe[0] <= ag_a;
      b_pipe[0] <= ag_b;
      for (int i = 1; i < D; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
      if (state != IDLE && mem.wr_en != mem.bfly_valid_out) sync_err <= 1'b1;
    end
  end

  assign mem.rd_en         = rd_en_q;
  assign mem.rd_addr_a     = ag_a;
  assign mem.rd_addr_b     = ag_b;
  assign mem.tw_addr       = ag_tw;
  assign mem.bfly_en       = bfly_en_q;
  assign mem.bfly_valid_in = rd_pipe[MEM_RD_LATENCY-1];
  assign mem.wr_en         = rd_pipe[D-1];
  assign mem.wr_addr_a     = a_pipe[D-1];
  assign mem.wr_addr_b     = b_pipe[D-1];

endmodule

// File: tb/tb_fft_dif_sequencer.sv
// Scoreboard bench for an 8-point sequencer (D = 4) with a 3-deep butterfly valid model.
module tb_fft_dif_sequencer;

  localparam int N         = 8;
  localparam int LG        = 3;
  localparam int STAGE_CYC = 8;   // N/2 + D
  localparam int WR_DELAY  = 4;   // D
  localparam int DONE_CYC  = 25;  // 1 + LOG2N*(N/2 + D)

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [LG-1:0] stage;
  logic          sync_err;
  logic          drop_valid = 1'b0;
  logic [2:0]    bpipe = '0;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  ev_t e;

  // Hand-derived pairs for N=8: stage 0, stage 1, stage 2
  int ea[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int eb[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int etw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

  fft_dif_sequencer_if #(.LOG2N(LG)) m ();

  fft_dif_sequencer #(
    .N_POINTS       (N),
    .BFLY_LATENCY   (3),
    .MEM_RD_LATENCY (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .sync_err (sync_err),
    .mem      (m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bpipe <= {bpipe[1:0], m.bfly_valid_in};
  assign m.bfly_valid_out = bpipe[2] & ~drop_valid;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d, expected none", name, cyc - base);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a read, write or done
  always @(negedge clk) begin
    if (m.rd_en === 1'b1) begin
      if (rd_q.size() == 0) unexpected("rd_extra");
      else begin
        e = rd_q.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_addr_a", int'(m.rd_addr_a), e.a);
        check("rd_addr_b", int'(m.rd_addr_b), e.b);
        check("tw_addr", int'(m.tw_addr), e.tw);
      end
    end
    if (m.wr_en === 1'b1) begin
      if (wr_q.size() == 0) unexpected("wr_extra");
      else begin
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr_a", int'(m.wr_addr_a), e.a);
        check("wr_addr_b", int'(m.wr_addr_b), e.b);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) unexpected("done_extra");
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int r);
    for (int i = 0; i < 200 && (cyc - base) < r; i++) tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    base  = cyc - 1;
    start = 1'b0;
  endtask

  task automatic push_events(input int n_rd, input int n_wr, input bit with_done);
    for (int i = 0; i < n_rd; i++)
      rd_q.push_back('{base + 1 + (i / 4) * STAGE_CYC + (i % 4), ea[i], eb[i], etw[i]});
    for (int i = 0; i < n_wr; i++)
      wr_q.push_back('{base + 1 + WR_DELAY + (i / 4) * STAGE_CYC + (i % 4), ea[i], eb[i], etw[i]});
    if (with_done) done_q.push_back(base + DONE_CYC);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_wr_left"}, wr_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stage", stage, 0);
    check("rst_rd_en", m.rd_en, 0);
    check("rst_wr_en", m.wr_en, 0);
    check("rst_bfly_en", m.bfly_en, 0);
    check("rst_bfly_valid_in", m.bfly_valid_in, 0);
    check("rst_sync_err", sync_err, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Run 1: restart while busy and start coincident with done are both ignored
    start_run();
    push_events(12, 12, 1'b1);
    go_to(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    go_to(25);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("run1_busy_after_done", busy, 0);
    go_to(32);
    check_drained("run1");
    check("run1_sync_err", sync_err, 0);

    // Run 2: one-cycle reset during stage 1 drain abandons the FFT
    start_run();
    push_events(8, 6, 1'b0);
    go_to(14);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_en", m.rd_en, 0);
    check("mid_rst_wr_en", m.wr_en, 0);
    check("mid_rst_bfly_valid_in", m.bfly_valid_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_stage", stage, 0);
    go_to(22);
    check_drained("run2");

    // Run 3: clean run after the aborted one
    start_run();
    push_events(12, 12, 1'b1);
    go_to(13);
    @(negedge clk);
    check("run3_bfly_en_drain", m.bfly_en, 1);
    check("run3_stage1", stage, 1);
    go_to(20);
    @(negedge clk);
    check("run3_stage2", stage, 2);
    go_to(26);
    @(negedge clk);
    check("run3_busy_after_done", busy, 0);
    check("run3_bfly_en_idle", m.bfly_en, 0);
    check("run3_stage_idle", stage, 0);
    go_to(30);
    check_drained("run3");
    check("run3_sync_err", sync_err, 0);

    // Run 4: a dropped butterfly valid makes sync_err sticky until reset
    start_run();
    push_events(12, 12, 1'b1);
    go_to(6);
    drop_valid = 1'b1;
    @(negedge clk);
    check("sync_err_before", sync_err, 0);
    tick();
    drop_valid = 1'b0;
    @(negedge clk);
    check("sync_err_rise", sync_err, 1);
    go_to(28);
    check("sync_err_sticky", sync_err, 1);
    check_drained("run4");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("sync_err_reset", sync_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
